// File: rtl/crc8_apb_sched.sv
// APB3 front-end and byte scheduler for a bit-serial CRC-8 engine; optional done IRQ via `CRC8_SCHED_IRQ_EN.
// Loads are spaced BYTE_CYCLES+1 cycles apart; CRC reads stall (pready low) until the queue and any clear drain.
module crc8_apb_sched #(
    parameter int FIFO_DEPTH  = 4,
    parameter int BYTE_CYCLES = 8,
    parameter int ADDR_W      = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic [31:0]       pwdata_i,
    output logic [31:0]       prdata_o,
    output logic              pready_o,
    output logic              pslverr_o,
    output logic [7:0]        crc_din_o,
    output logic              crc_valid_o,
    output logic              crc_rd_o,
    input  logic              crc_busy_i,
    input  logic [7:0]        crc_val_i,
    output logic              irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(BYTE_CYCLES) + 1;
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CLR, S_CWAIT} state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, level, clr_ahead;
    logic [CW-1:0] cnt;
    logic          clear_pending, overflow, done_bit;
    logic          empty, full, busy;
    logic          acc, data_wr, clear_wr, stat_wr, crc_rd, crc_stall, push, pop;
    logic [1:0]    off;
    logic [31:0]   status_word;
    logic          unused_bits;

    assign level = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign busy  = (state != S_IDLE) || !empty;

    assign acc       = psel_i & penable_i;
    assign off       = paddr_i[3:2];
    assign data_wr   = acc & pwrite_i & (off == 2'd0);
    assign stat_wr   = acc & pwrite_i & (off == 2'd2);
    assign clear_wr  = acc & pwrite_i & (off == 2'd3) & pwdata_i[0];
    assign crc_rd    = acc & !pwrite_i & (off == 2'd1);
    assign crc_stall = busy | clear_pending;
    assign push      = data_wr & !full;
    assign pop       = (state == S_LOAD);

    assign unused_bits = ^{paddr_i, pwdata_i[31:8]};

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= pwdata_i[7:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (data_wr && full)
                overflow <= 1'b1;
            else if (stat_wr && pwdata_i[3])
                overflow <= 1'b0;
        end
    end

    // clr_ahead counts FIFO entries queued before the pending clear; later bytes wait behind it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= S_IDLE;
            cnt           <= '0;
            crc_valid_o   <= 1'b0;
            crc_rd_o      <= 1'b0;
            crc_din_o     <= '0;
            clear_pending <= 1'b0;
            clr_ahead     <= '0;
        end else begin
            crc_valid_o <= 1'b0;
            crc_rd_o    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clear_pending && clr_ahead == '0 && !crc_busy_i) begin
                        state    <= S_CLR;
                        crc_rd_o <= 1'b1;
                    end else if (!empty && !crc_busy_i) begin
                        state       <= S_LOAD;
                        crc_valid_o <= 1'b1;
                        crc_din_o   <= mem[rd_ptr[AW-1:0]];
                    end
                end
                S_LOAD: begin
                    state <= S_RUN;
                    cnt   <= '0;
                end
                S_RUN: begin
                    // Exit on the incremented count so the next LOAD lands BYTE_CYCLES+1 cycles later.
                    cnt <= cnt + CW'(1);
                    if (cnt + CW'(1) == CW'(BYTE_CYCLES - 1)) state <= S_IDLE;
                end
                S_CLR:   state <= S_CWAIT;
                S_CWAIT: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (clear_wr && (!clear_pending || state == S_CLR)) begin
                clear_pending <= 1'b1;
                clr_ahead     <= level - (pop ? PTR_ONE : '0);
            end else if (state == S_CLR) begin
                clear_pending <= 1'b0;
            end else if (pop && clr_ahead != '0) begin
                clr_ahead <= clr_ahead - PTR_ONE;
            end
        end
    end

`ifdef CRC8_SCHED_IRQ_EN
    logic busy_q, done_irq;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q   <= 1'b0;
            done_irq <= 1'b0;
        end else begin
            busy_q <= busy;
            if (busy_q && !busy)
                done_irq <= 1'b1;
            else if (stat_wr && pwdata_i[4])
                done_irq <= 1'b0;
        end
    end

    assign done_bit = done_irq;
`else
    assign done_bit = 1'b0;
`endif

    assign irq_o = done_bit;

    assign status_word = {19'b0, 5'(level), 3'b0, done_bit, overflow, full, empty, busy};

    assign pready_o  = acc & !(crc_rd & crc_stall);
    assign pslverr_o = data_wr & full;

    always_comb begin
        prdata_o = '0;
        if (acc && !pwrite_i) begin
            case (off)
                2'd1:    if (!crc_stall) prdata_o = {24'b0, crc_val_i};
                2'd2:    prdata_o = status_word;
                default: prdata_o = '0;
            endcase
        end
    end
endmodule
